// File: rtl/i2c_min_pkg.sv
// rtl/i2c_min_pkg.sv - shared I2C target state encoding and ACK/NACK bus levels
package i2c_min_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      DATA,
      DATA_ACK,
      IGNORE
   } i2c_state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   // Address byte is {addr[6:0], rw}; only a write to our own address is accepted.
   function automatic logic addr_write_match(input logic [7:0] addr_byte, input logic [6:0] own);
      return (addr_byte[7:1] == own) && (addr_byte[0] == 1'b0);
   endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - bus-line synchronizer with rise/fall detect, preset to idle-high
module i2c_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_din,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_din};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_level = r_sync[STAGES-1];
   assign o_rise  = r_sync[STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_min_target.sv
// rtl/i2c_min_target.sv - minimal write-only I2C target with backpressured byte output
module i2c_min_target
   import i2c_min_pkg::*;
#(
   parameter logic [6:0] OWN_ADDR    = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       addressed,
   output logic       stop_det,
   output logic       overflow
);

   logic w_scl, w_scl_rise, w_scl_fall;
   logic w_sda, w_sda_rise, w_sda_fall;
   logic w_start, w_stop;

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .clk    (clk),
      .rst    (rst),
      .i_din  (scl_i),
      .o_level(w_scl),
      .o_rise (w_scl_rise),
      .o_fall (w_scl_fall)
   );

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .clk    (clk),
      .rst    (rst),
      .i_din  (sda_i),
      .o_level(w_sda),
      .o_rise (w_sda_rise),
      .o_fall (w_sda_fall)
   );

   assign w_start = w_sda_fall & w_scl;
   assign w_stop  = w_sda_rise & w_scl;

   i2c_state_t r_state;
   logic [2:0] r_bit_cnt;
   logic       r_full;
   logic [7:0] r_shift;
   logic       r_sda_o;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_addressed;
   logic       r_stop_det;
   logic       r_overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_bit_cnt   <= 3'd0;
         r_full      <= 1'b0;
         r_shift     <= 8'h00;
         r_sda_o     <= I2C_NACK;
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_addressed <= 1'b0;
         r_stop_det  <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_stop_det <= 1'b0;
         r_overflow <= 1'b0;
         // Bus conditions win over any SCL edge seen in the same cycle.
         if (w_stop) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_full      <= 1'b0;
            r_sda_o     <= I2C_NACK;
            r_addressed <= 1'b0;
            r_stop_det  <= 1'b1;
         end else if (w_start) begin
            r_state     <= ADDR;
            r_bit_cnt   <= 3'd0;
            r_full      <= 1'b0;
            r_sda_o     <= I2C_NACK;
            r_addressed <= 1'b0;
         end else begin
            case (r_state)
               ADDR, DATA: begin
                  if (w_scl_rise && !r_full) begin
                     r_shift <= {r_shift[6:0], w_sda};
                     if (r_bit_cnt == 3'd7) r_full <= 1'b1;
                     else                   r_bit_cnt <= r_bit_cnt + 3'd1;
                  end else if (w_scl_fall && r_full) begin
                     r_bit_cnt <= 3'd0;
                     r_full    <= 1'b0;
                     if (r_state == ADDR) begin
                        if (addr_write_match(r_shift, OWN_ADDR)) begin
                           r_state <= ADDR_ACK;
                           r_sda_o <= I2C_ACK;
                        end else begin
                           r_state <= IGNORE;
                           r_sda_o <= I2C_NACK;
                        end
                     end else if (rx_ready) begin
                        r_rx_data  <= r_shift;
                        r_rx_valid <= 1'b1;
                        r_state    <= DATA_ACK;
                        r_sda_o    <= I2C_ACK;
                     end else begin
                        r_overflow <= 1'b1;
                        r_state    <= IGNORE;
                        r_sda_o    <= I2C_NACK;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (w_scl_fall) begin
                     r_sda_o     <= I2C_NACK;
                     r_addressed <= 1'b1;
                     r_state     <= DATA;
                     r_bit_cnt   <= 3'd0;
                     r_full      <= 1'b0;
                  end
               end
               DATA_ACK: begin
                  if (w_scl_fall) begin
                     r_sda_o   <= I2C_NACK;
                     r_state   <= DATA;
                     r_bit_cnt <= 3'd0;
                     r_full    <= 1'b0;
                  end
               end
               default: r_sda_o <= I2C_NACK;
            endcase
         end
      end
   end

   assign sda_o     = r_sda_o;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign addressed = r_addressed;
   assign stop_det  = r_stop_det;
   assign overflow  = r_overflow;

endmodule

// File: doc/i2c_min_target.md
I2C_MIN_TARGET -- requirements
Module: i2c_min_target

Interface
REQ-001 SHALL have parameter OWN_ADDR, default 7'h50, the 7-bit target address the block answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on scl_i/sda_i (minimum 2).
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port scl_i, input, 1, the bus SCL level (asynchronous).
REQ-006 SHALL have port sda_i, input, 1, the bus SDA level (asynchronous).
REQ-007 SHALL have port sda_o, output, 1, the open-drain SDA drive; 0 pulls low, 1 releases.
REQ-008 SHALL have port rx_data, output, 8, the last received data byte, MSB first on the wire.
REQ-009 SHALL have port rx_valid, output, 1, a one-clk pulse when rx_data is updated.
REQ-010 SHALL have port rx_ready, input, 1; the consumer can accept a byte.
REQ-011 SHALL have port addressed, output, 1, high from own-address ACK until STOP or repeated START.
REQ-012 SHALL have port stop_det, output, 1, a one-clk pulse on every STOP condition.
REQ-013 SHALL have port overflow, output, 1, a one-clk pulse when a byte is NACKed because rx_ready was low.

Function
REQ-014 SHALL pass scl_i/sda_i through SYNC_STAGES flops and derive scl_rise, scl_fall, sda_rise and sda_fall from the synchronized levels.
REQ-015 SHALL detect START as sda_fall with synchronized SCL high, and STOP as sda_rise with synchronized SCL high.
REQ-016 SHALL sample SDA into the shift register on scl_rise only; data SHALL NOT be sampled on any other edge.
REQ-017 SHALL implement the states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK and IGNORE.
REQ-018 SHALL, in any state, go to ADDR on START with bit count cleared, release sda_o and clear addressed.
REQ-019 SHALL, in any state, go to IDLE on STOP, release sda_o, clear addressed and pulse stop_det.
REQ-020 SHALL, in ADDR, move on the 8th scl_fall: to ADDR_ACK if bits[7:1]==OWN_ADDR and bit0==0 (write), otherwise to IGNORE.
REQ-021 SHALL NACK a read-direction match (bit0==1), because the block is write-only; the block SHALL go to IGNORE.
REQ-022 SHALL, in ADDR_ACK, drive sda_o=0 from entry until the next scl_fall, then release it, set addressed and enter DATA.
REQ-023 SHALL, in DATA, on the 8th scl_fall: if rx_ready=1, load rx_data, pulse rx_valid and enter DATA_ACK with sda_o=0.
REQ-024 SHALL, in DATA, on the 8th scl_fall with rx_ready=0, pulse overflow, leave rx_data unchanged, hold sda_o=1 (NACK) and enter IGNORE.
REQ-025 SHALL, in DATA_ACK, release sda_o on the next scl_fall and return to DATA with bit count cleared.
REQ-026 SHALL keep sda_o=1 in IDLE and IGNORE until the next START or STOP.
REQ-027 SHALL use a 3-bit bit counter that counts scl_rise events (0..7) and wraps to 0 only on state entry; it SHALL never count beyond 8 bits.
REQ-028 SHALL give START or STOP priority over a coincident scl edge in the same clk.
REQ-029 SHALL pulse rx_valid, stop_det and overflow for exactly one clk each, with no back-to-back repeats per event.

Reset
REQ-030 SHALL, on rst: state=IDLE, sda_o=1, rx_data=8'h00, rx_valid=0, addressed=0, stop_det=0, overflow=0, bit counter=0, and synchronizer flops preset to 1 (bus idle).
REQ-031 SHALL, if rst is asserted mid-transfer, release sda_o in the same clk edge and ignore the bus until a fresh START.

Structure
REQ-032 SHALL define the state enum and constants I2C_ACK=1'b0 and I2C_NACK=1'b1 in the shared package i2c_min_pkg, to be reused by the existing master.
REQ-033 SHALL instantiate the sub-module i2c_sync_edge (synchronizer plus rise/fall detect) once for SCL and once for SDA.

Verification
REQ-034 SHALL cover: a write to 0x50 with byte 0xA5 and rx_ready=1 -> address ACK low for one SCL period, rx_valid once with rx_data=0xA5, data ACK, stop_det pulse, addressed=0 afterwards.
REQ-035 SHALL cover: a write to 0x51 -> sda_o stays 1 throughout, no rx_valid, addressed never set.
REQ-036 SHALL cover: a read to 0x50 (byte 0xA1) -> NACK, no rx_valid.
REQ-037 SHALL cover: bytes 0x12 and 0x34 with rx_ready dropped before the second byte -> rx_data=0x12 retained, one overflow pulse, second byte NACKed.
REQ-038 SHALL cover: a repeated START after byte 0x12, then address 0x50 and byte 0x56 -> addressed drops then re-asserts, rx_data=0x56.
REQ-039 SHALL cover: rst asserted during the ACK clock -> sda_o=1 on the next clk, and a following write of 0x77 is received correctly.
